// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_pkg
// Purpose  : Shared types for the Otter RV32I control path. Holds the
//            RV32I base opcode encodings and the multicycle sequencer state
//            encoding, used by both the decoder and otter_ctrl_fsm.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package otter_pkg;

   // RV32I base opcodes (ir[6:0])
   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      LOAD   = 7'b0000011,
      OP_IMM = 7'b0010011,
      BRANCH = 7'b1100011,
      STORE  = 7'b0100011,
      RTYPE  = 7'b0110011,
      SYS    = 7'b1110011
   } opcode_t;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_INTRPT = 3'd4
   } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/otter_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : otter_irq_arbiter
// Purpose  : Edge-latched, fixed-priority interrupt arbiter. Rising edges on
//            irq[i] set pending[i]; ack[i] clears it (a new edge in the same
//            cycle wins). Lowest pending index has the highest priority.
// Ports    : CLK, RST        - clock, async active-high reset
//            irq             - synchronous request lines
//            ack             - one-hot acknowledge of the serviced channel
//            any_pending     - at least one channel pending
//            grant_onehot    - lowest-index pending channel, one-hot
//            grant_id        - index of that channel
// Revision : 1.0 - initial release
// ============================================================================
module otter_irq_arbiter #(
   parameter int NUM_IRQ  = 4,
   parameter int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NUM_IRQ-1:0]  irq,
   input  logic [NUM_IRQ-1:0]  ack,
   output logic                any_pending,
   output logic [NUM_IRQ-1:0]  grant_onehot,
   output logic [IRQ_ID_W-1:0] grant_id
);

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] rise;

   assign rise = irq & ~irq_q;

   // Set is OR-ed in after the clear so a fresh edge survives its own ack.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         irq_q   <= '0;
         pending <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~ack) | rise;
      end
   end

   assign any_pending = |pending;

   // Scan from the top down so the lowest pending index is the last writer.
   always_comb begin
      grant_onehot = '0;
      grant_id     = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant_onehot    = '0;
            grant_onehot[i] = 1'b1;
            grant_id        = IRQ_ID_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/otter_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : otter_ctrl_fsm
// Purpose  : Multicycle control sequencer for the Otter RV32I core. Sequences
//            fetch / execute / writeback, stalls on mem_ready and enters an
//            interrupt cycle between instructions when enabled and pending.
// Ports    : CLK, RST            - clock, async active-high reset
//            opcode, func3       - fields of the current instruction
//            irq, irq_en         - interrupt lines and global enable
//            mem_ready           - memory completes the access this cycle
//            rst_out             - reset strobe to PC / register file
//            pc_we, rf_we, csr_we- architectural write enables
//            mem_rden1           - instruction read
//            mem_rden2, mem_we2  - data read / write
//            int_taken           - interrupt entry cycle
//            mret_exec           - mret retiring
//            illegal_op          - unrecognised instruction retiring as NOP
//            irq_ack, irq_id     - serviced channel (one-hot / index)
// Revision : 1.0 - initial release
// ============================================================================
module otter_ctrl_fsm
   import otter_pkg::*;
#(
   parameter int NUM_IRQ  = 4,
   parameter int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [6:0]          opcode,
   input  logic [2:0]          func3,
   input  logic [NUM_IRQ-1:0]  irq,
   input  logic                irq_en,
   input  logic                mem_ready,
   output logic                rst_out,
   output logic                pc_we,
   output logic                rf_we,
   output logic                csr_we,
   output logic                mem_rden1,
   output logic                mem_rden2,
   output logic                mem_we2,
   output logic                int_taken,
   output logic                mret_exec,
   output logic                illegal_op,
   output logic [NUM_IRQ-1:0]  irq_ack,
   output logic [IRQ_ID_W-1:0] irq_id
);

   ctrl_state_t          state;
   ctrl_state_t          after_retire;
   opcode_t              op;
   logic                 retire;
   logic                 any_pending;
   logic [NUM_IRQ-1:0]   grant_onehot;
   logic [IRQ_ID_W-1:0]  grant_id;

   assign op = opcode_t'(opcode);

   otter_irq_arbiter #(
      .NUM_IRQ  (NUM_IRQ),
      .IRQ_ID_W (IRQ_ID_W)
   ) u_arb (
      .CLK          (CLK),
      .RST          (RST),
      .irq          (irq),
      .ack          (irq_ack),
      .any_pending  (any_pending),
      .grant_onehot (grant_onehot),
      .grant_id     (grant_id)
   );

   // Interrupt decision is taken in the retiring cycle only.
   assign after_retire = (irq_en && any_pending) ? ST_INTRPT : ST_FETCH;

   always_comb begin
      rst_out    = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      csr_we     = 1'b0;
      mem_rden1  = 1'b0;
      mem_rden2  = 1'b0;
      mem_we2    = 1'b0;
      int_taken  = 1'b0;
      mret_exec  = 1'b0;
      illegal_op = 1'b0;
      irq_ack    = '0;
      irq_id     = '0;
      retire     = 1'b0;
      case (state)
         ST_INIT:  rst_out   = 1'b1;
         ST_FETCH: mem_rden1 = 1'b1;
         ST_EXEC: begin
            case (op)
               LOAD: mem_rden2 = 1'b1;
               STORE: begin
                  mem_we2 = 1'b1;
                  if (mem_ready) begin
                     pc_we  = 1'b1;
                     retire = 1'b1;
                  end
               end
               BRANCH: begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end
               LUI, AUIPC, JAL, JALR, OP_IMM, RTYPE: begin
                  pc_we  = 1'b1;
                  rf_we  = 1'b1;
                  retire = 1'b1;
               end
               SYS: begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
                  case (func3)
                     3'b000: mret_exec = 1'b1;
                     3'b001: begin
                        rf_we  = 1'b1;
                        csr_we = 1'b1;
                     end
                     default: illegal_op = 1'b1;
                  endcase
               end
               default: begin
                  pc_we      = 1'b1;
                  illegal_op = 1'b1;
                  retire     = 1'b1;
               end
            endcase
         end
         ST_WB: begin
            mem_rden2 = 1'b1;
            if (mem_ready) begin
               rf_we  = 1'b1;
               pc_we  = 1'b1;
               retire = 1'b1;
            end
         end
         ST_INTRPT: begin
            int_taken = 1'b1;
            pc_we     = 1'b1;
            irq_ack   = grant_onehot;
            irq_id    = grant_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_INIT;
      end else begin
         case (state)
            ST_INIT:   state <= ST_FETCH;
            ST_FETCH:  if (mem_ready) state <= ST_EXEC;
            ST_EXEC: begin
               if (op == LOAD) state <= ST_WB;
               else if (retire) state <= after_retire;
            end
            ST_WB:     if (retire) state <= after_retire;
            ST_INTRPT: state <= ST_FETCH;
            default:   state <= ST_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_otter_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_ctrl_fsm
// Purpose  : Self-checking bench for otter_ctrl_fsm (NUM_IRQ = 4). Each
//            instruction is expanded into its expected cycle list from the
//            instruction-class timing rules; interrupt pending state is kept
//            as a bitmask updated from request edges and acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_ctrl_fsm;

   localparam int N = 4;

   // Control vector bit positions, MSB first:
   // rst_out pc_we rf_we csr_we rden1 rden2 we2 int_taken mret illegal
   localparam logic [9:0] C_RST  = 10'b1000000000;
   localparam logic [9:0] C_PC   = 10'b0100000000;
   localparam logic [9:0] C_RF   = 10'b0010000000;
   localparam logic [9:0] C_CSR  = 10'b0001000000;
   localparam logic [9:0] C_RD1  = 10'b0000100000;
   localparam logic [9:0] C_RD2  = 10'b0000010000;
   localparam logic [9:0] C_WE2  = 10'b0000001000;
   localparam logic [9:0] C_INT  = 10'b0000000100;
   localparam logic [9:0] C_MRET = 10'b0000000010;
   localparam logic [9:0] C_ILL  = 10'b0000000001;

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_OPIMM = 7'h13;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_RTYPE = 7'h33;
   localparam logic [6:0] OP_SYS   = 7'h73;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic [6:0]   opcode = '0;
   logic [2:0]   func3 = '0;
   logic [N-1:0] irq = '0;
   logic         irq_en = 1'b0;
   logic         mem_ready = 1'b0;
   logic         rst_out, pc_we, rf_we, csr_we, mem_rden1, mem_rden2, mem_we2;
   logic         int_taken, mret_exec, illegal_op;
   logic [N-1:0] irq_ack;
   logic [1:0]   irq_id;

   otter_ctrl_fsm #(.NUM_IRQ(N)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .opcode     (opcode),
      .func3      (func3),
      .irq        (irq),
      .irq_en     (irq_en),
      .mem_ready  (mem_ready),
      .rst_out    (rst_out),
      .pc_we      (pc_we),
      .rf_we      (rf_we),
      .csr_we     (csr_we),
      .mem_rden1  (mem_rden1),
      .mem_rden2  (mem_rden2),
      .mem_we2    (mem_we2),
      .int_taken  (int_taken),
      .mret_exec  (mret_exec),
      .illegal_op (illegal_op),
      .irq_ack    (irq_ack),
      .irq_id     (irq_id)
   );

   always #5 CLK = ~CLK;

   int           n_chk = 0;
   int           n_fail = 0;
   logic [N-1:0] m_pend = '0;   // reference pending mask
   logic [N-1:0] m_prev = '0;   // last irq value seen at a clock edge
   bit           rnd = 1'b0;    // randomise irq / irq_en / don't-care ready
   bit           hook = 1'b0;   // force hook_irq during the next INTRPT cycle
   logic [N-1:0] hook_irq = '0;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [9:0] ex;
   } vec_t;
   vec_t vecs[12];

   function automatic logic [15:0] outs();
      return {rst_out, pc_we, rf_we, csr_we, mem_rden1, mem_rden2, mem_we2,
              int_taken, mret_exec, illegal_op, irq_ack, irq_id};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // Expected EXEC-cycle controls for single-cycle-execute instructions.
   function automatic logic [9:0] exp_exec(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_RTYPE: return C_PC | C_RF;
         OP_BR:  return C_PC;
         OP_SYS: return (f3 == 3'b000) ? (C_PC | C_MRET) :
                        (f3 == 3'b001) ? (C_PC | C_RF | C_CSR) : (C_PC | C_ILL);
         default: return C_PC | C_ILL;
      endcase
   endfunction

   // Inputs are already applied; check, then cross the edge and update model.
   task automatic cyc(input string nm, input logic [9:0] ec, input logic [N-1:0] eack,
                      input logic [1:0] eid);
      #2;
      chk(nm, outs(), {ec, eack, eid});
      @(posedge CLK);
      m_pend = (m_pend & ~eack) | (irq & ~m_prev);
      m_prev = irq;
      #1;
   endtask

   task automatic prep();
      if (rnd) begin
         if ($urandom_range(3) == 0) irq = irq ^ N'(1 << $urandom_range(N - 1));
         irq_en = ($urandom_range(3) != 0);
      end
   endtask

   task automatic retire_cyc(input string nm, input logic [9:0] ctl);
      logic         take;
      logic [N-1:0] a;
      take = irq_en && (m_pend != '0);
      cyc(nm, ctl, '0, '0);
      if (take) begin
         prep();
         if (hook) begin
            irq  = hook_irq;
            hook = 1'b0;
         end
         a = m_pend & (~m_pend + 1'b1);
         cyc("intrpt", C_INT | C_PC, a, 2'($clog2(a)));
      end
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                        input int mw, input logic [9:0] ex);
      opcode = op;
      func3  = f3;
      for (int i = 0; i < fw; i++) begin
         prep(); mem_ready = 1'b0; cyc("fetch_wait", C_RD1, '0, '0);
      end
      prep(); mem_ready = 1'b1; cyc("fetch", C_RD1, '0, '0);
      if (op == OP_LOAD) begin
         prep(); mem_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         cyc("load_exec", C_RD2, '0, '0);
         for (int i = 0; i < mw; i++) begin
            prep(); mem_ready = 1'b0; cyc("load_wait", C_RD2, '0, '0);
         end
         prep(); mem_ready = 1'b1; retire_cyc("load_wb", C_RD2 | C_RF | C_PC);
      end else if (op == OP_STORE) begin
         for (int i = 0; i < mw; i++) begin
            prep(); mem_ready = 1'b0; cyc("store_wait", C_WE2, '0, '0);
         end
         prep(); mem_ready = 1'b1; retire_cyc("store", C_WE2 | C_PC);
      end else begin
         prep(); mem_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         retire_cyc("exec", ex);
      end
   endtask

   initial begin
      logic [6:0] ops[12];
      logic [6:0] rop;
      logic [2:0] rf3;

      vecs[0]  = '{OP_OPIMM, 3'd0, C_PC | C_RF};
      vecs[1]  = '{OP_LUI,   3'd5, C_PC | C_RF};
      vecs[2]  = '{OP_AUIPC, 3'd1, C_PC | C_RF};
      vecs[3]  = '{OP_JAL,   3'd7, C_PC | C_RF};
      vecs[4]  = '{OP_JALR,  3'd0, C_PC | C_RF};
      vecs[5]  = '{OP_BR,    3'd1, C_PC};
      vecs[6]  = '{OP_RTYPE, 3'd4, C_PC | C_RF};
      vecs[7]  = '{OP_SYS,   3'd0, C_PC | C_MRET};
      vecs[8]  = '{OP_SYS,   3'd1, C_PC | C_RF | C_CSR};
      vecs[9]  = '{OP_SYS,   3'd2, C_PC | C_ILL};
      vecs[10] = '{7'h7F,    3'd0, C_PC | C_ILL};
      vecs[11] = '{7'h0B,    3'd3, C_PC | C_ILL};

      // Reset: outputs show INIT asynchronously.
      #1 RST = 1'b1;
      #2 chk("reset_outs", outs(), {C_RST, 4'b0, 2'b0});
      @(posedge CLK); @(posedge CLK);
      #1 RST = 1'b0;
      cyc("init", C_RST, '0, '0);

      // Table: ADDI first (INIT->FETCH->EXEC->FETCH), then the rest.
      for (int i = 0; i < 12; i++) instr(vecs[i].op, vecs[i].f3, 0, 0, vecs[i].ex);

      // LOAD with three WB wait cycles, and a stalled fetch.
      instr(OP_LOAD, 3'd2, 1, 3, '0);
      instr(OP_STORE, 3'd2, 0, 2, '0);

      // Two channels rising together during an RTYPE: serviced 1 then 3.
      irq_en = 1'b1;
      opcode = OP_RTYPE;
      irq = 4'b1010;
      instr(OP_RTYPE, 3'd0, 0, 0, C_PC | C_RF);
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq = 4'b0000;
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);

      // irq[0] held high with interrupts disabled, then enabled: one entry.
      irq_en = 1'b0;
      irq = 4'b0001;
      for (int i = 0; i < 5; i++) instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq_en = 1'b1;
      for (int i = 0; i < 3; i++) instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq = 4'b0000;

      // New edge on irq[2] in the same cycle as its acknowledge.
      irq_en = 1'b0;
      irq = 4'b0100;
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq = 4'b0000;
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq_en = 1'b1;
      hook = 1'b1;
      hook_irq = 4'b0100;
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);
      irq = 4'b0000;
      instr(OP_OPIMM, 3'd0, 0, 0, C_PC | C_RF);

      // Reset during a STORE wait with a channel pending.
      irq_en = 1'b0;
      opcode = OP_STORE;
      irq = 4'b0001;
      mem_ready = 1'b1;
      cyc("fetch", C_RD1, '0, '0);
      mem_ready = 1'b0;
      cyc("store_wait", C_WE2, '0, '0);
      irq = 4'b0000;
      RST = 1'b1;
      #1 chk("rst_abort_outs", outs(), {C_RST, 4'b0, 2'b0});
      chk("rst_abort_pending", {12'b0, dut.u_arb.pending}, 16'b0);
      m_pend = '0;
      m_prev = '0;
      @(posedge CLK);
      #1 RST = 1'b0;
      cyc("init", C_RST, '0, '0);
      instr(7'h7F, 3'd0, 0, 0, C_PC | C_ILL);

      // Randomised instruction stream with random interrupts.
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM,
              OP_BR, OP_STORE, OP_RTYPE, OP_SYS, 7'h7F, 7'h0B};
      rnd = 1'b1;
      for (int k = 0; k < 150; k++) begin
         rop = ops[$urandom_range(11)];
         rf3 = 3'($urandom_range(7));
         if (rop == OP_SYS && $urandom_range(1) == 0) rf3 = 3'($urandom_range(1));
         instr(rop, rf3, $urandom_range(2), $urandom_range(2), exp_exec(rop, rf3));
      end
      rnd = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Safety net: the run is bounded well below this.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/otter_ctrl_fsm.md
# otter_ctrl_fsm

Multicycle control sequencer for the Otter RV32I core. It replaces the single-cycle decoder's implicit `int_taken` input with its own interrupt logic: a parametrised, prioritised, edge-latched interrupt controller. It sequences fetch, execute and writeback, and stalls on a memory ready handshake. It sits between instruction memory/IR and the PC, register file, CSR file and data memory. ALU/mux select decoding stays in the combinational decoder.

## Interface
- `NUM_IRQ`, default 4: number of interrupt channels, legal range 1..16.
- `IRQ_ID_W`, default `NUM_IRQ>1 ? $clog2(NUM_IRQ) : 1`: width of `irq_id`.
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `opcode`, input, 7: ir[6:0].
- `func3`, input, 3: ir[14:12].
- `irq`, input, NUM_IRQ: synchronous interrupt request lines.
- `irq_en`, input, 1: global interrupt enable (CSR mstatus.MIE).
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `rst_out`, output, 1: reset strobe to PC and register file.
- `pc_we`, output, 1: PC write enable.
- `rf_we`, output, 1: register file write enable.
- `csr_we`, output, 1: CSR write enable.
- `mem_rden1`, output, 1: instruction read.
- `mem_rden2`, output, 1: data read.
- `mem_we2`, output, 1: data write.
- `int_taken`, output, 1: interrupt entry; drives decoder `int_taken`.
- `mret_exec`, output, 1: mret retiring.
- `illegal_op`, output, 1: unrecognised opcode retiring as NOP.
- `irq_ack`, output, NUM_IRQ: one-hot acknowledge of the serviced channel.
- `irq_id`, output, IRQ_ID_W: index of the serviced channel.

## Operation
- States: INIT, FETCH, EXEC, WB, INTRPT.
- Outputs are combinational from state, opcode, func3, mem_ready and the arbiter. Every output is 0 unless stated.
- INIT: `rst_out=1`. Always goes to FETCH next.
- FETCH: `mem_rden1=1`. Goes to EXEC when `mem_ready`; otherwise stays in FETCH.
- EXEC, LOAD: `mem_rden2=1`. Goes to WB.
- EXEC, STORE: `mem_we2=1`. If `mem_ready`: `pc_we=1` and the instruction retires; otherwise stays in EXEC with `pc_we=0`.
- EXEC, BRANCH/JAL/JALR/LUI/AUIPC/OP_IMM/RTYPE: `pc_we=1`. `rf_we=1` for every opcode in this group except BRANCH. Instruction retires.
- EXEC, SYS func3=000: `pc_we=1`, `mret_exec=1`. Retires.
- EXEC, SYS func3=001: `pc_we=1`, `rf_we=1`, `csr_we=1`. Retires.
- EXEC, SYS with any other func3, or any other opcode: `pc_we=1`, `illegal_op=1`. No other writes. Retires.
- WB: `mem_rden2=1`. If `mem_ready`: `rf_we=1`, `pc_we=1`, retires; otherwise stays in WB.
- Retire transition: goes to INTRPT if `irq_en && |pending`, else FETCH. This is sampled in the retiring cycle.
- INTRPT: `int_taken=1`, `pc_we=1`. `irq_ack` is one-hot on the lowest-index pending channel and `irq_id` is that index. The acknowledged pending bit clears at the clock edge. Always goes to FETCH.
- Pending register: bit i sets on a rising edge of `irq[i]`, detected against a registered copy of `irq`. A level held high does not re-pend. Bit i clears on `irq_ack[i]`.
- Set and clear on the same bit in the same cycle: set wins.
- Interrupts are never taken mid-instruction, and never while in FETCH or INIT.
- `irq_en` low: edges keep latching into pending; no INTRPT entry.

## Timing
- Reset: state=INIT, pending=0, registered `irq` copy=0. Outputs during reset: `rst_out=1`, all others 0.
- `RST` asserted mid-instruction aborts immediately. Memory strobes drop asynchronously with the state change.
- Zero-wait memory (`mem_ready` tied high): ALU instruction takes 2 cycles; store 2; load 3. Interrupt entry adds 1 cycle.
- Each wait cycle on `mem_ready` adds exactly 1 cycle. Strobes stay asserted and stable throughout the wait.
- Edge-to-pending latency: 1 cycle after the edge is sampled.
- mret and a pending interrupt in the same retiring cycle: mret retires, then INTRPT if `irq_en` was high in that cycle.

## Structure
- `otter_pkg` holds the `opcode_t` enum (LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, BRANCH, STORE, RTYPE, SYS) and the `ctrl_state_t` enum. The decoder and this block share the package.
- Sub-module `otter_irq_arbiter`, parametrised by `NUM_IRQ`, contains:
  - the edge detector;
  - the pending register;
  - the fixed-priority encoder, with outputs `any_pending`, `grant_onehot` and `grant_id`;
  - the `ack` input.
- The FSM and output decode live in the top module.

## Test plan
- Reset then ADDI with `mem_ready=1`: INIT→FETCH→EXEC→FETCH. `pc_we` and `rf_we` high only in EXEC; `rst_out` high only in INIT.
- LOAD with `mem_ready` low for 3 WB cycles: `mem_rden2` held for 4 cycles; `rf_we`/`pc_we` high in the final WB cycle only.
- `NUM_IRQ=4`, `irq=4'b1010` rising together, `irq_en=1`, during an RTYPE: INTRPT with `irq_id=1`, `irq_ack=4'b0010`. Next retire: INTRPT with `irq_id=3`.
- `irq[0]` held high for 10 cycles with `irq_en=0`, then `irq_en=1`: exactly one INTRPT. No re-entry while the level stays high.
- New edge on `irq[2]` in the same cycle as `irq_ack[2]`: pending[2] remains 1 and is serviced again.
- `RST` during a STORE wait (`mem_ready=0`): `mem_we2` drops, state=INIT, pending=0, `rst_out=1`. Opcode 7'b1111111 retires with `illegal_op=1` and `rf_we=0`.
